// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory access controller
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int IO_BIT_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane select/extend for loads and lane merge for stores
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] rbuf,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] load_val,
    output logic        misalign
);

    logic [4:0]  lane_lsb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        lane_lsb = {addr_lo, 3'b000};
        byte_sel = rbuf[lane_lsb +: 8];
        half_sel = addr_lo[1] ? rbuf[31:16] : rbuf[15:0];
        merged   = rbuf;
        load_val = rbuf;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                merged[lane_lsb +: 8] = wdata[7:0];
                load_val = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
                load_val = {{16{sign_ext & half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            SZ_WORD: begin
                merged   = wdata;
                misalign = |addr_lo;
            end
            default: begin
                merged   = rbuf;
                load_val = rbuf;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage bus initiator: word/half/byte loads and stores, sub-word stores as RMW
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int IO_BIT = IO_BIT_DEF,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       datain,
    output logic              we,
    input  logic [31:0]       dataout
);

    state_t              state_q;
    logic                write_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [1:0]          addr_lo_q;
    logic [31:0]         wdata_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         datain_q;
    logic                we_q;
    logic                resp_valid_q;
    logic                resp_err_q;
    logic [31:0]         resp_rdata_q;

    logic                idle;
    logic [1:0]          al_addr_lo;
    logic [1:0]          al_size;
    logic [31:0]         al_merged;
    logic [31:0]         al_load;
    logic                al_misalign;
    logic                req_err;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the aligner vets the incoming request; afterwards it works on the latched one.
    assign al_addr_lo = idle ? req_addr[1:0] : addr_lo_q;
    assign al_size    = idle ? req_size      : size_q;

    // The read word is merged/extended as it arrives, so datain and resp_rdata are registered on the RD edge.
    mem_lane_align u_align (
        .addr_lo  (al_addr_lo),
        .size     (al_size),
        .sign_ext (signed_q),
        .rbuf     (dataout),
        .wdata    (wdata_q),
        .merged   (al_merged),
        .load_val (al_load),
        .misalign (al_misalign)
    );

    assign req_err = (req_size == SZ_ILLEGAL) | al_misalign |
                     (req_addr[IO_BIT] & (req_size != SZ_WORD));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            addr_lo_q    <= 2'b00;
            wdata_q      <= 32'h0;
            addr_q       <= '0;
            datain_q     <= 32'h0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        if (req_err) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            state_q      <= ST_RESP;
                        end else begin
                            addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_write && (req_size == SZ_WORD)) begin
                                datain_q <= req_wdata;
                                we_q     <= 1'b1;
                                state_q  <= ST_WR;
                            end else begin
                                state_q <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (write_q) begin
                        datain_q <= al_merged;
                        we_q     <= 1'b1;
                        state_q  <= ST_WR;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= al_load;
                        state_q      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    we_q         <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = idle;
    assign busy       = ~idle;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign addr       = addr_q;
    assign datain     = datain_q;
    assign we         = we_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, resp_valid, resp_err, we;
    logic [31:0] resp_rdata, addr, datain, dataout;
    logic        mem_clr;
    logic [31:0] mem [0:63];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clock = ~clock;

    dmem_access_ctrl #(.IO_BIT(7), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .addr(addr),
        .datain(datain), .we(we), .dataout(dataout)
    );

    assign dataout = mem[addr[7:2]];

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (we) begin
            mem[addr[7:2]] <= datain;
        end
    end

    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output int we_cnt, output logic [31:0] we_addr,
                           output logic [31:0] we_data, output logic err, output logic [31:0] rdata);
        lat = -1; we_cnt = 0; we_addr = 32'h0; we_data = 32'h0; err = 1'b0; rdata = 32'hX;
        @(negedge clock);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = ~w; req_size = 2'b10; req_signed = ~sg; req_addr = 32'hFFFF_FFFC; req_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (we) begin we_cnt++; we_addr = addr; we_data = datain; end
            if (resp_valid && lat < 0) begin lat = c; err = resp_err; rdata = resp_rdata; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", req_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if ({we, resp_valid, resp_err} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {we, resp_valid, resp_err}); else n_pass++;
        n_checks++; if ({addr, datain, resp_rdata} !== 96'h0) $display("FAIL rst_regs: got %h %h %h expected zeros", addr, datain, resp_rdata); else n_pass++;
        reset = 1'b0; mem_clr = 1'b0;
    endtask

    task automatic test_word_store_load;
        int lat, wc; logic [31:0] wa, wdt, rd; logic e;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, lat, wc, wa, wdt, e, rd);
        n_checks++; if (lat !== 2) $display("FAIL sw_lat: got %0d expected 2", lat); else n_pass++;
        n_checks++; if (wc !== 1) $display("FAIL sw_we_cycles: got %0d expected 1", wc); else n_pass++;
        n_checks++; if (wa !== 32'h10) $display("FAIL sw_addr: got %h expected 00000010", wa); else n_pass++;
        n_checks++; if (mem[4] !== 32'h1234_5678) $display("FAIL sw_mem: got %h expected 12345678", mem[4]); else n_pass++;
        n_checks++; if (e !== 1'b0 || rd !== 32'h0) $display("FAIL sw_resp: got err %b rdata %h expected 0 00000000", e, rd); else n_pass++;
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, wc, wa, wdt, e, rd);
        n_checks++; if (lat !== 2) $display("FAIL lw_lat: got %0d expected 2", lat); else n_pass++;
        n_checks++; if (rd !== 32'h1234_5678) $display("FAIL lw_data: got %h expected 12345678", rd); else n_pass++;
        n_checks++; if (wc !== 0) $display("FAIL lw_we: got %0d expected 0", wc); else n_pass++;
    endtask

    task automatic test_rmw;
        int lat, wc; logic [31:0] wa, wdt, rd; logic e;
        run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABB_CCDD, lat, wc, wa, wdt, e, rd);
        run_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_005A, lat, wc, wa, wdt, e, rd);
        n_checks++; if (lat !== 3) $display("FAIL sb_lat: got %0d expected 3", lat); else n_pass++;
        n_checks++; if (wc !== 1) $display("FAIL sb_we_cycles: got %0d expected 1", wc); else n_pass++;
        n_checks++; if (wa !== 32'h20) $display("FAIL sb_addr: got %h expected 00000020", wa); else n_pass++;
        n_checks++; if (wdt !== 32'hAA5A_CCDD) $display("FAIL sb_datain: got %h expected aa5accdd", wdt); else n_pass++;
        run_req(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_1111, lat, wc, wa, wdt, e, rd);
        n_checks++; if (wdt !== 32'hAA5A_1111) $display("FAIL sh_datain: got %h expected aa5a1111", wdt); else n_pass++;
        n_checks++; if (lat !== 3 || wc !== 1) $display("FAIL sh_timing: got lat %0d we %0d expected 3 1", lat, wc); else n_pass++;
    endtask

    task automatic test_extension;
        int lat, wc; logic [31:0] wa, wdt, rd; logic e;
        run_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF_7F81, lat, wc, wa, wdt, e, rd);
        run_req(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, lat, wc, wa, wdt, e, rd);
        n_checks++; if (rd !== 32'hFFFF_FF81) $display("FAIL lb: got %h expected ffffff81", rd); else n_pass++;
        run_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, lat, wc, wa, wdt, e, rd);
        n_checks++; if (rd !== 32'h0000_0081) $display("FAIL lbu: got %h expected 00000081", rd); else n_pass++;
        run_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, lat, wc, wa, wdt, e, rd);
        n_checks++; if (rd !== 32'hFFFF_80FF) $display("FAIL lh: got %h expected ffff80ff", rd); else n_pass++;
        run_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, lat, wc, wa, wdt, e, rd);
        n_checks++; if (rd !== 32'h0000_80FF) $display("FAIL lhu: got %h expected 000080ff", rd); else n_pass++;
        run_req(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, lat, wc, wa, wdt, e, rd);
        n_checks++; if (rd !== 32'h0000_007F) $display("FAIL lb_lane1: got %h expected 0000007f", rd); else n_pass++;
    endtask

    task automatic test_errors;
        int lat, wc; logic [31:0] wa, wdt, rd; logic e;
        logic        ew   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  esz  [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
        logic [31:0] ea   [4] = '{32'h22, 32'h21, 32'h40, 32'h84};
        for (int i = 0; i < 4; i++) begin
            run_req(ew[i], esz[i], 1'b0, ea[i], 32'h0000_00EE, lat, wc, wa, wdt, e, rd);
            n_checks++; if (lat !== 1 || e !== 1'b1) $display("FAIL err%0d_resp: got lat %0d err %b expected 1 1", i, lat, e); else n_pass++;
            n_checks++; if (wc !== 0 || rd !== 32'h0) $display("FAIL err%0d_bus: got we %0d rdata %h expected 0 00000000", i, wc, rd); else n_pass++;
        end
        n_checks++; if (mem[8] !== 32'hAA5A_1111 || mem[33] !== 32'h0) $display("FAIL err_mem: got %h %h expected aa5a1111 00000000", mem[8], mem[33]); else n_pass++;
    endtask

    task automatic test_io;
        int lat, wc; logic [31:0] wa, wdt, rd; logic e;
        run_req(1'b1, 2'b10, 1'b0, 32'h80, 32'h0000_00FF, lat, wc, wa, wdt, e, rd);
        n_checks++; if (wa !== 32'h80 || wc !== 1 || wdt !== 32'hFF) $display("FAIL io_st: got addr %h we %0d data %h expected 00000080 1 000000ff", wa, wc, wdt); else n_pass++;
        run_req(1'b1, 2'b10, 1'b0, 32'h88, 32'hCAFE_F00D, lat, wc, wa, wdt, e, rd);
        run_req(1'b0, 2'b10, 1'b0, 32'h88, 32'h0, lat, wc, wa, wdt, e, rd);
        n_checks++; if (rd !== 32'hCAFE_F00D || e !== 1'b0) $display("FAIL io_ld: got %h err %b expected cafef00d 0", rd, e); else n_pass++;
    endtask

    task automatic test_reset_midop;
        int lat, wc; logic [31:0] wa, wdt, rd; logic e;
        int seen_we, seen_resp;
        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h1122_3344, lat, wc, wa, wdt, e, rd);
        @(negedge clock);
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h41; req_wdata = 32'h99;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b1 || we !== 1'b0) $display("FAIL rm_rd: got busy %b we %b expected 1 0", busy, we); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL rm_idle: got busy %b ready %b expected 0 1", busy, req_ready); else n_pass++;
        n_checks++; if (we !== 1'b0 || resp_valid !== 1'b0) $display("FAIL rm_out: got we %b resp %b expected 0 0", we, resp_valid); else n_pass++;
        reset = 1'b0;
        seen_we = 0; seen_resp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (we) seen_we++;
            if (resp_valid) seen_resp++;
        end
        n_checks++; if (seen_we !== 0 || seen_resp !== 0) $display("FAIL rm_quiet: got we %0d resp %0d expected 0 0", seen_we, seen_resp); else n_pass++;
        n_checks++; if (mem[16] !== 32'h1122_3344) $display("FAIL rm_mem: got %h expected 11223344", mem[16]); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int n_ready, n_resp, n_bad;
        n_ready = 0; n_resp = 0; n_bad = 0;
        @(negedge clock);
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid = 1'b1;
        #1;
        for (int c = 0; c < 9; c++) begin
            if (req_ready) n_ready++;
            if (resp_valid) begin
                n_resp++;
                if (resp_rdata !== 32'h1234_5678) n_bad++;
            end
            @(negedge clock);
            #1;
        end
        req_valid = 1'b0;
        n_checks++; if (n_ready !== 3) $display("FAIL b2b_accepts: got %0d expected 3", n_ready); else n_pass++;
        n_checks++; if (n_resp !== 3) $display("FAIL b2b_resps: got %0d expected 3", n_resp); else n_pass++;
        n_checks++; if (n_bad !== 0) $display("FAIL b2b_data: got %0d bad expected 0", n_bad); else n_pass++;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_rmw();
        test_extension();
        test_errors();
        test_io();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
